// File: rtl/mmio_fifo_mac_if.sv
// Word stream from the MMIO write FIFO into the multiply-accumulate block.
// Latency: none, wires only.
// Backpressure: the consumer pops only when in_valid and in_ready are both high.
interface mmio_fifo_mac_if #(
    parameter int OP_W = 32
);
    logic                in_valid;
    logic [2*OP_W-1:0]   in_data;
    logic                in_ready;

    // FIFO side drives the word and valid, sees the pop
    modport master (output in_valid, output in_data, input in_ready);
    // MAC side consumes the word and drives the pop
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/mmio_fifo_mac.sv
// Signed multiply-accumulate over a host-programmed number of FIFO words.
// Latency: one product stage; final acc_out and done visible one edge after the last pop.
// Backpressure: in_ready high only in RUN while count < len; stalls indefinitely on in_valid low.
module mmio_fifo_mac #(
    parameter int OP_W  = 32,
    parameter int ACC_W = 64,
    parameter int LEN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    mmio_fifo_mac_if.slave          in_if,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic                    start,
    input  logic                    clr,
    output logic [ACC_W-1:0]        acc_out,
    output logic [LEN_W-1:0]        count,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        count_q, count_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [ACC_W-1:0]        p_q, p_d;
    logic                    p_vld_q, p_vld_d;
    logic                    ovf_q, ovf_d;
    logic                    done_q, done_d;

    logic signed [OP_W-1:0]   op_a, op_b;
    logic signed [2*OP_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]         sum;
    logic                     sum_ovf;
    logic [LEN_W-1:0]         count_inc;
    logic                     in_ready_c;
    logic                     hs;

    // Operand split and full-width signed product; -2^31 * -2^31 fits in 2*OP_W bits
    assign op_a     = in_if.in_data[OP_W-1:0];
    assign op_b     = in_if.in_data[2*OP_W-1:OP_W];
    assign prod     = op_a * op_b;
    assign prod_ext = ACC_W'(prod);

    // Accumulate with wraparound; overflow when addend signs agree and result sign differs
    assign sum     = acc_q + p_q;
    assign sum_ovf = (acc_q[ACC_W-1] == p_q[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

    assign count_inc  = count_q + LEN_W'(1);
    assign in_ready_c = (state_q == RUN) && (count_q < len_q);
    assign hs         = in_if.in_valid && in_ready_c;

    // Next-state: pipeline stages, job sequencing, and clr overriding everything
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        acc_d   = acc_q;
        p_d     = p_q;
        p_vld_d = p_vld_q;
        ovf_d   = ovf_q;
        done_d  = done_q;

        // Stage 2: fold the pending product into the accumulator
        if (p_vld_q) begin
            acc_d   = sum;
            ovf_d   = ovf_q | sum_ovf;
            p_vld_d = 1'b0;
        end

        // Stage 1: a pop loads a fresh product, keeping the pipe full back-to-back
        if (hs) begin
            p_d     = prod_ext;
            p_vld_d = 1'b1;
            count_d = count_inc;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    len_d   = cfg_len;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    p_vld_d = 1'b0;
                    if (cfg_len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        done_d  = 1'b0;
                    end
                end
            end
            RUN: begin
                if (hs && (count_inc == len_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (p_vld_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr) begin
            state_d = IDLE;
            len_d   = '0;
            count_d = '0;
            acc_d   = '0;
            p_d     = '0;
            p_vld_d = 1'b0;
            ovf_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            p_vld_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            p_vld_q <= p_vld_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign in_if.in_ready = in_ready_c;
    assign acc_out        = acc_q;
    assign count          = count_q;
    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = done_q;
    assign ovf            = ovf_q;

endmodule

// File: tb/tb_mmio_fifo_mac.sv
// Directed bench for mmio_fifo_mac with hand-computed expectations.
// Latency: inputs change #1 after a rising edge, outputs checked #1 after the next edge.
// Backpressure: stall patterns toggle in_valid; in_ready observed before each edge.
module tb_mmio_fifo_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_len;
    logic        start;
    logic        clr;
    logic [63:0] acc_out;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt [7];
    logic stall_vld [7];
    int acc_hs;

    mmio_fifo_mac_if #(.OP_W(32)) in_if ();

    mmio_fifo_mac #(.OP_W(32), .ACC_W(64), .LEN_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_if   (in_if),
        .cfg_len (cfg_len),
        .start   (start),
        .clr     (clr),
        .acc_out (acc_out),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word(input int a, input int b);
        logic [31:0] ua;
        logic [31:0] ub;
        ua = a;
        ub = b;
        return {ub, ua};
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; clr = 1'b0; cfg_len = '0;
        in_if.in_valid = 1'b0; in_if.in_data = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_acc", acc_out, 64'd0);
        chk("rst_count", {48'd0, count}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        chk("rst_ready", {63'd0, in_if.in_ready}, 64'd0);
        step();

        // Basic job: (3,4),(-2,5),(7,-1) -> 12-10-7 = -5
        cfg_len = 16'd3; start = 1'b1;
        step();
        start = 1'b0;
        chk("basic_busy", {63'd0, busy}, 64'd1);
        acc_hs = 0;
        in_if.in_valid = 1'b1; in_if.in_data = word(3, 4);
        if (in_if.in_ready) acc_hs++;
        step();
        in_if.in_data = word(-2, 5);
        if (in_if.in_ready) acc_hs++;
        step();
        in_if.in_data = word(7, -1);
        if (in_if.in_ready) acc_hs++;
        step();
        in_if.in_data = word(100, 100);
        if (in_if.in_ready) acc_hs++;
        chk("basic_accepts", 64'(acc_hs), 64'd3);
        chk("basic_count", {48'd0, count}, 64'd3);
        chk("basic_done_early", {63'd0, done}, 64'd0);
        step();
        in_if.in_valid = 1'b0;
        chk("basic_done", {63'd0, done}, 64'd1);
        chk("basic_acc", acc_out, 64'hFFFF_FFFF_FFFF_FFFB);
        chk("basic_ovf", {63'd0, ovf}, 64'd0);
        chk("basic_busy_end", {63'd0, busy}, 64'd0);
        step();
        chk("basic_hold_acc", acc_out, 64'hFFFF_FFFF_FFFF_FFFB);
        chk("basic_hold_count", {48'd0, count}, 64'd3);

        // Restart from DONE: (6,7) -> 42
        cfg_len = 16'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_done_drop", {63'd0, done}, 64'd0);
        chk("restart_acc_clear", acc_out, 64'd0);
        in_if.in_valid = 1'b1; in_if.in_data = word(6, 7);
        step();
        in_if.in_valid = 1'b0;
        step();
        chk("restart_acc", acc_out, 64'd42);
        chk("restart_done", {63'd0, done}, 64'd1);
        chk("restart_count", {48'd0, count}, 64'd1);

        // Zero length with valid data offered
        cfg_len = 16'd0; start = 1'b1; in_if.in_valid = 1'b1; in_if.in_data = word(9, 9);
        chk("zero_ready_pre", {63'd0, in_if.in_ready}, 64'd0);
        step();
        start = 1'b0;
        chk("zero_done", {63'd0, done}, 64'd1);
        chk("zero_acc", acc_out, 64'd0);
        chk("zero_count", {48'd0, count}, 64'd0);
        chk("zero_ready", {63'd0, in_if.in_ready}, 64'd0);
        step();
        chk("zero_count_hold", {48'd0, count}, 64'd0);
        in_if.in_valid = 1'b0;

        // Stalls: valid pattern 1,0,0,1,1,0,1 with (1,1); a mid-job start is ignored
        exp_cnt   = '{1, 1, 1, 2, 3, 3, 4};
        stall_vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        cfg_len = 16'd4; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_if.in_valid = stall_vld[i];
            in_if.in_data  = word(1, 1);
            start   = (i == 1);
            cfg_len = (i == 1) ? 16'd9 : 16'd4;
            step();
            chk($sformatf("stall_count%0d", i), {48'd0, count}, 64'(exp_cnt[i]));
            chk($sformatf("stall_busy%0d", i), {63'd0, busy}, 64'd1);
        end
        in_if.in_valid = 1'b0; start = 1'b0;
        step();
        chk("stall_done", {63'd0, done}, 64'd1);
        chk("stall_acc", acc_out, 64'd4);
        chk("stall_busy_end", {63'd0, busy}, 64'd0);

        // Overflow: three (-2^31,-2^31) products of 2^62 each
        cfg_len = 16'd3; start = 1'b1;
        step();
        start = 1'b0;
        in_if.in_valid = 1'b1; in_if.in_data = {32'h8000_0000, 32'h8000_0000};
        step();
        step();
        chk("ovf_first_acc", acc_out, 64'h4000_0000_0000_0000);
        chk("ovf_first_flag", {63'd0, ovf}, 64'd0);
        step();
        in_if.in_valid = 1'b0;
        step();
        chk("ovf_acc", acc_out, 64'hC000_0000_0000_0000);
        chk("ovf_flag", {63'd0, ovf}, 64'd1);
        chk("ovf_done", {63'd0, done}, 64'd1);
        step();
        chk("ovf_sticky", {63'd0, ovf}, 64'd1);

        // Abort after 2 handshakes with start in the same cycle as clr
        cfg_len = 16'd5; start = 1'b1;
        step();
        start = 1'b0;
        in_if.in_valid = 1'b1; in_if.in_data = word(1, 2);
        step();
        step();
        chk("abort_count_pre", {48'd0, count}, 64'd2);
        clr = 1'b1; start = 1'b1;
        step();
        clr = 1'b0; start = 1'b0; in_if.in_valid = 1'b0;
        chk("abort_acc", acc_out, 64'd0);
        chk("abort_count", {48'd0, count}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_ready", {63'd0, in_if.in_ready}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        step();
        chk("abort_idle", {63'd0, busy}, 64'd0);
        chk("abort_acc_hold", acc_out, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
